// File: rtl/regfile_pkg.sv
// Shared register-file types and constants for the writeback path.
package regfile_pkg;

  localparam int REG_ADDR_W = 4;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 2 ** REG_ADDR_W;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t addr;
    reg_data_t data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// N-way round-robin grant: one-hot pointer marks the highest-priority requester,
// grant is combinational and the pointer moves past the winner on advance.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  logic [N-1:0]   r_ptr;
  logic [2*N-1:0] w_req_dbl;
  logic [2*N-1:0] w_gnt_dbl;

  // Doubling the request vector lets the borrow chain of the subtraction
  // find the first request at or after the pointer, wrapping around.
  assign w_req_dbl = {req, req};
  assign w_gnt_dbl = w_req_dbl & ~(w_req_dbl - {{N{1'b0}}, r_ptr});
  assign gnt       = w_gnt_dbl[N-1:0] | w_gnt_dbl[2*N-1:N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= N'(1);
    end else if (advance && (|gnt)) begin
      r_ptr <= {gnt[N-2:0], gnt[N-1]};
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter in front of the register-file write port.
// Optional busy scoreboard compiled in when REGFILE_SCOREBOARD_EN is defined.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = REG_DATA_W,
  parameter int ADDR_W  = REG_ADDR_W
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_data,
  output logic                            wr_en,
  output logic [ADDR_W-1:0]               write_addr,
  output logic [DATA_W-1:0]               write_data,
  input  logic                            claim_valid,
  input  logic [ADDR_W-1:0]               claim_addr,
  output logic [(2**ADDR_W)-1:0]          busy
);

  localparam int LOCAL_REGS = 2 ** ADDR_W;

  logic [NUM_REQ-1:0] w_gnt;
  logic               w_xfer;
  logic [ADDR_W-1:0]  w_win_addr;
  logic [DATA_W-1:0]  w_win_data;
  logic               r_wr_en;
  logic [ADDR_W-1:0]  r_write_addr;
  logic [DATA_W-1:0]  r_write_data;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr_arbiter (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .advance (w_xfer),
    .gnt     (w_gnt)
  );

  // No handshake is offered while reset is held, so in-flight requests are dropped.
  assign req_ready = w_gnt & {NUM_REQ{rst_n}};
  assign w_xfer    = |(req_valid & req_ready);

  always_comb begin
    w_win_addr = '0;
    w_win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_win_addr = w_win_addr | req_addr[i];
        w_win_data = w_win_data | req_data[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en      <= 1'b0;
      r_write_addr <= '0;
      r_write_data <= '0;
    end else begin
      r_wr_en <= w_xfer;
      if (w_xfer) begin
        r_write_addr <= w_win_addr;
        r_write_data <= w_win_data;
      end
    end
  end

  assign wr_en      = r_wr_en;
  assign write_addr = r_write_addr;
  assign write_data = r_write_data;

`ifdef REGFILE_SCOREBOARD_EN
  logic [LOCAL_REGS-1:0] r_busy;

  // A claim landing on the commit edge wins: a newer producer is outstanding.
  for (genvar gi = 0; gi < LOCAL_REGS; gi++) begin : g_busy
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_busy[gi] <= 1'b0;
      end else if (claim_valid && (claim_addr == ADDR_W'(gi))) begin
        r_busy[gi] <= 1'b1;
      end else if (r_wr_en && (r_write_addr == ADDR_W'(gi))) begin
        r_busy[gi] <= 1'b0;
      end
    end
  end

  assign busy = r_busy;
`else
  logic w_unused_claim;

  assign w_unused_claim = ^{claim_valid, claim_addr};
  assign busy           = {LOCAL_REGS{1'b0}};
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed cases then random traffic,
// with a behavioural grant/busy model. Honours REGFILE_SCOREBOARD_EN like the RTL.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  localparam int N = 2;

  logic                           clk = 1'b0;
  logic                           rst_n = 1'b0;
  logic [N-1:0]                   req_valid;
  logic [N-1:0]                   req_ready;
  logic [N-1:0][REG_ADDR_W-1:0]   req_addr;
  logic [N-1:0][REG_DATA_W-1:0]   req_data;
  logic                           wr_en;
  reg_addr_t                      write_addr;
  reg_data_t                      write_data;
  logic                           claim_valid;
  reg_addr_t                      claim_addr;
  logic [NUM_REGS-1:0]            busy;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(
    .NUM_REQ (N),
    .DATA_W  (REG_DATA_W),
    .ADDR_W  (REG_ADDR_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .wr_en       (wr_en),
    .write_addr  (write_addr),
    .write_data  (write_data),
    .claim_valid (claim_valid),
    .claim_addr  (claim_addr),
    .busy        (busy)
  );

  typedef struct packed {
    reg_addr_t addr;
    reg_data_t data;
  } wr_t;

  int                          n_cmp = 0;
  int                          n_bad = 0;
  wr_t                         exp_q[$];
  int                          m_ptr = 0;
  logic [NUM_REGS-1:0]         m_busy = '0;
  logic                        m_commit_v = 1'b0;
  reg_addr_t                   m_commit_a = '0;
  reg_data_t                   rf [NUM_REGS];
  logic [N-1:0]                prev_v = '0;
  logic [N-1:0]                prev_g = '0;
  logic [N-1:0][REG_ADDR_W-1:0] cur_a = '0;
  logic [N-1:0][REG_DATA_W-1:0] cur_d = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the expected write whenever the register file is written.
  always @(negedge clk) begin
    wr_t e;
    chk("wr_en", {63'd0, wr_en}, {63'd0, m_commit_v});
    chk("busy", 64'(busy), 64'(m_busy));
    if (wr_en === 1'b1 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("write_addr", 64'(write_addr), 64'(e.addr));
      chk("write_data", 64'(write_data), 64'(e.data));
      $display("write r%0d = %08h", write_addr, write_data);
      rf[write_addr] = write_data;
    end
  end

  // Called just after a rising edge; returns just after the next one.
  task automatic drive_cycle(input logic [N-1:0] v,
                             input logic [N-1:0][REG_ADDR_W-1:0] a,
                             input logic [N-1:0][REG_DATA_W-1:0] d,
                             input logic cv, input reg_addr_t ca);
    int w;
    logic [N-1:0] exp_g;
    logic [NUM_REGS-1:0] nxt_busy;
    req_valid   = v;
    req_addr    = a;
    req_data    = d;
    claim_valid = cv;
    claim_addr  = ca;
    w = -1;
    for (int k = 0; k < N; k++) begin
      if (w < 0 && v[(m_ptr + k) % N]) w = (m_ptr + k) % N;
    end
    exp_g = '0;
    if (w >= 0) begin
      exp_g[w] = 1'b1;
      exp_q.push_back(wr_t'{addr: a[w], data: d[w]});
      m_ptr = (w + 1) % N;
    end
    #2;
    chk("req_ready", 64'(req_ready), 64'(exp_g));
    nxt_busy = m_busy;
`ifdef REGFILE_SCOREBOARD_EN
    if (m_commit_v) nxt_busy[m_commit_a] = 1'b0;
    if (cv) nxt_busy[ca] = 1'b1;
`endif
    prev_v = v;
    prev_g = exp_g;
    @(posedge clk);
    m_busy     = nxt_busy;
    m_commit_v = (w >= 0);
    if (w >= 0) m_commit_a = a[w];
    #1;
  endtask

  task automatic idle(input logic cv, input reg_addr_t ca);
    drive_cycle('0, '0, '0, cv, ca);
  endtask

  task automatic random_cycle();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) begin
      if (prev_v[i] && !prev_g[i]) begin
        v[i] = ($urandom_range(0, 7) != 0);
      end else begin
        v[i]     = 1'($urandom_range(0, 1));
        cur_a[i] = REG_ADDR_W'($urandom_range(0, NUM_REGS - 1));
        cur_d[i] = $urandom;
      end
    end
    drive_cycle(v, cur_a, cur_d, ($urandom_range(0, 3) == 0),
                REG_ADDR_W'($urandom_range(0, NUM_REGS - 1)));
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ptr      = 0;
    m_busy     = '0;
    m_commit_v = 1'b0;
    prev_v     = '0;
    prev_g     = '0;
  endtask

  initial begin
    req_valid   = '0;
    req_addr    = '0;
    req_data    = '0;
    claim_valid = 1'b0;
    claim_addr  = '0;
    #3;
    chk("reset_wr_en", {63'd0, wr_en}, 64'd0);
    chk("reset_write_addr", 64'(write_addr), 64'd0);
    chk("reset_write_data", 64'(write_data), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Contention from a fresh pointer: grants alternate 0,1,0,1.
    for (int i = 0; i < 4; i++)
      drive_cycle(2'b11, {4'd2, 4'd1}, {32'h22, 32'h11}, 1'b0, '0);
    idle(1'b0, '0);

    drive_cycle(2'b01, {4'd0, 4'd3}, {32'h0, 32'hDEADBEEF}, 1'b0, '0);
    idle(1'b0, '0);
    idle(1'b0, '0);
    chk("rf_r3", 64'(rf[3]), 64'hDEADBEEF);

    drive_cycle(2'b10, {4'd5, 4'd0}, {32'hAAAA0000, 32'h0}, 1'b0, '0);
    drive_cycle(2'b01, {4'd0, 4'd5}, {32'h0, 32'h0000BBBB}, 1'b0, '0);
    idle(1'b0, '0);
    idle(1'b0, '0);
    chk("rf_r5_last_wins", 64'(rf[5]), 64'h0000BBBB);

    // Claim r7, write r7, re-claim on the commit edge, then write r7 again.
    idle(1'b1, 4'd7);
    drive_cycle(2'b01, {4'd0, 4'd7}, {32'h0, 32'h77}, 1'b0, '0);
    idle(1'b1, 4'd7);
    idle(1'b0, '0);
    drive_cycle(2'b01, {4'd0, 4'd7}, {32'h0, 32'h78}, 1'b0, '0);
    idle(1'b0, '0);
    idle(1'b0, '0);
    chk("rf_r7", 64'(rf[7]), 64'h78);

    for (int i = 0; i < 400; i++) random_cycle();
    idle(1'b0, '0);
    idle(1'b0, '0);

    // Reset asserted mid-cycle with req0 valid: nothing may be written.
    req_valid = 2'b01;
    req_addr  = {4'd0, 4'd9};
    req_data  = {32'h0, 32'h99};
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("midreset_wr_en", {63'd0, wr_en}, 64'd0);
    chk("midreset_write_addr", 64'(write_addr), 64'd0);
    chk("midreset_write_data", 64'(write_data), 64'd0);
    chk("midreset_busy", 64'(busy), 64'd0);
    chk("midreset_req_ready", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1;
    chk("inreset_wr_en", {63'd0, wr_en}, 64'd0);
    #2;
    req_valid = '0;
    rst_n     = 1'b1;
    @(posedge clk);
    #1;

    // Pointer restarts at requester 0.
    drive_cycle(2'b11, {4'd4, 4'd6}, {32'h44, 32'h66}, 1'b0, '0);
    drive_cycle(2'b11, {4'd4, 4'd6}, {32'h44, 32'h66}, 1'b0, '0);
    for (int i = 0; i < 50; i++) random_cycle();
    idle(1'b0, '0);
    idle(1'b0, '0);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

- Shares the register file's single synchronous write port between `NUM_REQ` writeback requesters, such as the ALU result and the load-data return.
- Arbitration is round-robin with per-requester valid/ready handshakes.
- The winning write is registered onto the register file's `wr_en`/`write_addr`/`write_data` inputs.
- An optional per-register busy scoreboard lets the issue stage stall on registers with writes still in flight.
- Sits between the execute/memory stages and the 16x32 register file.

## Interface
Parameters:
- `NUM_REQ`, 2: number of writeback requesters (2..4).
- `DATA_W`, 32: write data width.
- `ADDR_W`, 4: register address width; `NUM_REGS = 2**ADDR_W`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  `NUM_REQ`  requester i holds a write.
- `req_ready`  out  `NUM_REQ`  requester i's write is accepted this cycle.
- `req_addr`  in  `NUM_REQ` x `ADDR_W`  destination register per requester.
- `req_data`  in  `NUM_REQ` x `DATA_W`  write data per requester.
- `wr_en`  out  1  register-file write enable (registered).
- `write_addr`  out  `ADDR_W`  register-file write address (registered).
- `write_data`  out  `DATA_W`  register-file write data (registered).
- `claim_valid`  in  1  issue stage reserves a destination register.
- `claim_addr`  in  `ADDR_W`  register being reserved.
- `busy`  out  `NUM_REGS`  bit r set means a write to register r is pending.

## Operation
**Arbitration**
- Round-robin pointer `rr_ptr` (`NUM_REQ`-bit one-hot) marks the highest-priority requester.
- Each cycle, the first valid requester at or after `rr_ptr` (wrapping) is granted.
- `req_ready` is combinational; at most one bit is high, and only for the granted requester.
- `req_ready[i]` never depends on `req_ready` of any other requester.
- Transfer occurs when `req_valid[i] && req_ready[i]`.
- After a transfer, `rr_ptr` rotates to the requester after the winner. With no transfer, `rr_ptr` holds.
- Requesters must hold `req_addr`/`req_data` stable while valid and not ready. Dropping valid before the transfer is allowed.

**Output register**
- On a transfer: `wr_en` <= 1, `write_addr` <= winner's `req_addr`, `write_data` <= winner's `req_data`.
- With no transfer: `wr_en` <= 0, and `write_addr`/`write_data` hold their values.
- The arbiter is never backpressured: one write retires per cycle, so every cycle with any valid request grants one.

**Scoreboard** (only when `REGFILE_SCOREBOARD_EN` is defined)
- `claim_valid` sets `busy[claim_addr]` at the next edge.
- A register-file commit (`wr_en` == 1 at an edge) clears `busy[write_addr]`.
- If a set and a clear hit the same register at the same edge, the set wins (a newer producer is outstanding).
- Clearing an already-clear bit is a no-op.

**Reset**
- Applies asynchronously: `wr_en` = 0, `write_addr` = 0, `write_data` = 0, `busy` = 0, `rr_ptr` = requester 0.
- A request in flight during reset is discarded, with no write and no handshake.
- After `rst_n` rises, the first grant can occur at the first edge.

## Timing
- Request accepted at edge N, so `wr_en` is high during cycle N+1.
- The register file stores the data at edge N+1. Its asynchronous read returns the new value from edge N+1 onward.
- `busy` bit cleared by the commit at edge N+1.
- `busy` is registered with no combinational path from `claim_*`. A claim at edge N is visible after edge N.
- Worst-case wait for a requester held valid: `NUM_REQ`-1 grants.
- Two requesters writing the same register in consecutive grants are committed in grant order; the last write wins.

## Configuration
- `REGFILE_SCOREBOARD_EN` defined: scoreboard flops and `claim_*` logic compiled in, as described above.
- `REGFILE_SCOREBOARD_EN` not defined:
  - `busy` is tied to 0 and `claim_valid`/`claim_addr` are ignored.
  - No scoreboard flops are generated.
  - Arbitration and write timing are unchanged.

## Structure
- Shared package `regfile_pkg` holds:
  - constants `REG_ADDR_W` = 4, `REG_DATA_W` = 32, `NUM_REGS` = 16;
  - typedef `reg_addr_t`;
  - typedef `reg_data_t`;
  - packed struct `wb_req_t` {valid, addr, data}.
- Sub-module `rr_arbiter`: parameterized N-way round-robin grant. Ports: `clk`, `rst_n`, `req`[N], `advance`, `gnt`[N] (one-hot, combinational).
- `regfile_wb_arbiter` contains the output register and the scoreboard.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-cycle while req0 is valid → `wr_en`, `write_addr`, `write_data` and `busy` all 0 immediately; no write is issued.
- **Single requester:** req0 valid, addr 3, data 0xDEADBEEF at edge N → `req_ready[0]` = 1 during cycle N; `wr_en` = 1 and `write_addr` = 3 in cycle N+1; register-file read of r3 returns 0xDEADBEEF after edge N+1.
- **Contention:** req0 and req1 both valid and held for 4 cycles (addr 1/2, data 0x11/0x22), `rr_ptr` = 0 → grants alternate 0,1,0,1; `write_addr` sequence 1,2,1,2; never two ready bits high in one cycle.
- **Same-register ordering:** req1 writes r5 = 0xAAAA0000, then req0 writes r5 = 0x0000BBBB in the next grant → r5 reads 0x0000BBBB.
- **Scoreboard** (`REGFILE_SCOREBOARD_EN`):
  - claim r7 → `busy[7]` = 1 next cycle;
  - req0 writes r7 → `busy[7]` = 0 after the commit edge;
  - a claim of r7 on the commit edge itself → `busy[7]` stays 1.
- **Macro off:** repeat the scoreboard stimulus → `busy` = 0 throughout; write sequence identical to the previous run.
